// File: rtl/sdram_client_arbiter.sv
// Two-client round-robin arbiter in front of the SDRAM controller, one operation outstanding at a time.
// Latency: controller pulse one cycle after the request is taken; client ack one cycle after the controller ack.
// Backpressure: clients hold a level request until their ack; a watchdog aborts with err if the controller never acks.
module sdram_client_arbiter #(
  parameter int ADDR_W         = 22,
  parameter int DATA_W         = 128,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              iclk,
  input  logic              ireset,
  input  logic              ia_req,
  input  logic              ia_we,
  input  logic [ADDR_W-1:0] ia_address,
  input  logic [DATA_W-1:0] ia_wdata,
  output logic              oa_ack,
  output logic              oa_err,
  output logic [DATA_W-1:0] oa_rdata,
  input  logic              ib_req,
  input  logic              ib_we,
  input  logic [ADDR_W-1:0] ib_address,
  input  logic [DATA_W-1:0] ib_wdata,
  output logic              ob_ack,
  output logic              ob_err,
  output logic [DATA_W-1:0] ob_rdata,
  output logic              osd_write_req,
  output logic [ADDR_W-1:0] osd_write_address,
  output logic [DATA_W-1:0] osd_write_data,
  input  logic              isd_write_ack,
  output logic              osd_read_req,
  output logic [ADDR_W-1:0] osd_read_address,
  input  logic [DATA_W-1:0] isd_read_data,
  input  logic              isd_read_ack,
  input  logic              isd_init_done,
  output logic              obusy,
  output logic              ogrant
);

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_t;

  // Last WAIT count before the watchdog fires (counter starts at 0 on the first WAIT cycle).
  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      state;
  state_t      state_nxt;
  logic        op_we;
  logic        err_flag;
  logic [15:0] wait_cnt;
  logic        any_req;
  logic        win_b;
  logic        ack_match;
  logic        timeout;

  // Arbitration and completion decode: on a tie the client not served last wins.
  always_comb begin
    any_req   = ia_req | ib_req;
    win_b     = ib_req & (~ia_req | ~ogrant);
    ack_match = op_we ? isd_write_ack : isd_read_ack;
    timeout   = (wait_cnt == CNT_LAST);
  end

  // State register; an async reset drops any in-flight transaction without an ack.
  always_ff @(posedge iclk or posedge ireset) begin
    if (ireset) state <= S_INIT;
    else        state <= state_nxt;
  end

  // Next-state logic; a matching ack wins over a simultaneous timeout.
  always_comb begin
    state_nxt = state;
    case (state)
      S_INIT:  if (isd_init_done) state_nxt = S_IDLE;
      S_IDLE: begin
        if (!isd_init_done) state_nxt = S_INIT;
        else if (any_req)   state_nxt = S_ISSUE;
      end
      S_ISSUE: state_nxt = S_WAIT;
      S_WAIT:  if (ack_match || timeout) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_INIT;
    endcase
  end

  // Latch the winning client's operation; the osd_* fields then hold until the next grant.
  always_ff @(posedge iclk or posedge ireset) begin
    if (ireset) begin
      ogrant            <= 1'b1;
      op_we             <= 1'b0;
      osd_write_address <= '0;
      osd_read_address  <= '0;
      osd_write_data    <= '0;
    end else if (state == S_IDLE && isd_init_done && any_req) begin
      ogrant            <= win_b;
      op_we             <= win_b ? ib_we : ia_we;
      osd_write_address <= win_b ? ib_address : ia_address;
      osd_read_address  <= win_b ? ib_address : ia_address;
      osd_write_data    <= win_b ? ib_wdata : ia_wdata;
    end
  end

  // Watchdog counter and completion status; read data is captured only on a real read ack.
  always_ff @(posedge iclk or posedge ireset) begin
    if (ireset) begin
      wait_cnt <= '0;
      err_flag <= 1'b0;
      oa_rdata <= '0;
      ob_rdata <= '0;
    end else begin
      if (state == S_ISSUE) begin
        wait_cnt <= '0;
      end else if (state == S_WAIT) begin
        wait_cnt <= wait_cnt + 16'd1;
        if (ack_match) begin
          err_flag <= 1'b0;
          if (!op_we) begin
            if (ogrant) ob_rdata <= isd_read_data;
            else        oa_rdata <= isd_read_data;
          end
        end else if (timeout) begin
          err_flag <= 1'b1;
        end
      end
    end
  end

  // Controller pulses come from ISSUE, client acks from DONE, steered by the grant.
  always_comb begin
    osd_write_req = (state == S_ISSUE) &  op_we;
    osd_read_req  = (state == S_ISSUE) & ~op_we;
    oa_ack        = (state == S_DONE)  & ~ogrant;
    ob_ack        = (state == S_DONE)  &  ogrant;
    oa_err        = oa_ack & err_flag;
    ob_err        = ob_ack & err_flag;
    obusy         = (state == S_ISSUE) | (state == S_WAIT) | (state == S_DONE);
  end

endmodule

// File: tb/tb_sdram_client_arbiter.sv
// Directed bench for sdram_client_arbiter: init gating, write, read, round robin, watchdog, async reset.
// Latency: all checks sampled on the falling edge, inputs driven there too.
// Backpressure: the controller side is a hand-driven model inside the single initial block.
module tb_sdram_client_arbiter;

  localparam int AW = 22;
  localparam int DW = 128;

  logic          iclk = 1'b0;
  logic          ireset;
  logic          ia_req, ia_we, ib_req, ib_we;
  logic [AW-1:0] ia_address, ib_address;
  logic [DW-1:0] ia_wdata, ib_wdata;
  logic          oa_ack, oa_err, ob_ack, ob_err;
  logic [DW-1:0] oa_rdata, ob_rdata;
  logic          osd_write_req, osd_read_req;
  logic [AW-1:0] osd_write_address, osd_read_address;
  logic [DW-1:0] osd_write_data;
  logic          isd_write_ack, isd_read_ack, isd_init_done;
  logic [DW-1:0] isd_read_data;
  logic          obusy, ogrant;

  int total_cnt = 0;
  int pass_cnt  = 0;
  int fail_cnt  = 0;

  localparam logic [DW-1:0] WDATA = 128'hDEADBEEFCAFEBABE123456789ABCDEF0;

  sdram_client_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(8)) dut (
    .iclk(iclk), .ireset(ireset),
    .ia_req(ia_req), .ia_we(ia_we), .ia_address(ia_address), .ia_wdata(ia_wdata),
    .oa_ack(oa_ack), .oa_err(oa_err), .oa_rdata(oa_rdata),
    .ib_req(ib_req), .ib_we(ib_we), .ib_address(ib_address), .ib_wdata(ib_wdata),
    .ob_ack(ob_ack), .ob_err(ob_err), .ob_rdata(ob_rdata),
    .osd_write_req(osd_write_req), .osd_write_address(osd_write_address),
    .osd_write_data(osd_write_data), .isd_write_ack(isd_write_ack),
    .osd_read_req(osd_read_req), .osd_read_address(osd_read_address),
    .isd_read_data(isd_read_data), .isd_read_ack(isd_read_ack),
    .isd_init_done(isd_init_done), .obusy(obusy), .ogrant(ogrant)
  );

  always #5 iclk = ~iclk;

  task automatic chk(input string tag, input logic obs, input logic exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to the falling edge of the ISSUE cycle, bounded.
  task automatic wait_pulse(input string tag);
    int n;
    n = 0;
    while (!(osd_write_req | osd_read_req) && n < 12) begin
      @(negedge iclk);
      n++;
    end
    chk(tag, logic'(n < 12), 1'b1);
  endtask

  task automatic apply_reset();
    ireset = 1'b1;
    repeat (2) @(negedge iclk);
    ireset = 1'b0;
  endtask

  initial begin
    logic seen;
    ireset = 1'b1;
    ia_req = 0; ia_we = 0; ia_address = '0; ia_wdata = '0;
    ib_req = 0; ib_we = 0; ib_address = '0; ib_wdata = '0;
    isd_write_ack = 0; isd_read_ack = 0; isd_init_done = 0; isd_read_data = '0;
    repeat (2) @(negedge iclk);

    // Reset values
    chk("rst oa_ack", oa_ack, 1'b0);
    chk("rst ob_ack", ob_ack, 1'b0);
    chk("rst wr_req", osd_write_req, 1'b0);
    chk("rst rd_req", osd_read_req, 1'b0);
    chkw("rst wr_addr", DW'(osd_write_address), '0);
    chkw("rst wr_data", osd_write_data, '0);
    chkw("rst oa_rdata", oa_rdata, '0);
    chk("rst busy", obusy, 1'b0);
    chk("rst grant", ogrant, 1'b1);
    ireset = 1'b0;

    // Init gating: A requests a write while the controller is not ready
    ia_req = 1; ia_we = 1; ia_address = 22'h000001; ia_wdata = WDATA;
    seen = 1'b0;
    repeat (20) begin
      @(negedge iclk);
      seen = seen | osd_write_req | osd_read_req | obusy;
    end
    chk("init no pulse", seen, 1'b0);
    isd_init_done = 1;
    @(negedge iclk);                               // IDLE
    chk("init idle no pulse", osd_write_req, 1'b0);
    @(negedge iclk);                               // ISSUE
    chk("wr pulse", osd_write_req, 1'b1);
    chk("wr no rd", osd_read_req, 1'b0);
    chkw("wr addr", DW'(osd_write_address), DW'(22'h000001));
    chkw("wr data", osd_write_data, WDATA);
    chk("wr grant", ogrant, 1'b0);
    chk("wr busy", obusy, 1'b1);
    seen = 1'b0;
    repeat (4) begin
      @(negedge iclk);
      seen = seen | osd_write_req | oa_ack | ob_ack;
    end
    chk("wr single pulse", seen, 1'b0);
    @(negedge iclk);
    isd_write_ack = 1;
    @(negedge iclk);                               // DONE
    isd_write_ack = 0;
    chk("wr oa_ack", oa_ack, 1'b1);
    chk("wr oa_err", oa_err, 1'b0);
    chk("wr ob_ack", ob_ack, 1'b0);
    ia_req = 0;
    @(negedge iclk);
    chk("wr ack one cycle", oa_ack, 1'b0);
    chk("wr idle busy", obusy, 1'b0);

    // B reads the same line; a write ack during WAIT is ignored
    ib_req = 1; ib_we = 0; ib_address = 22'h000001;
    @(negedge iclk);                               // ISSUE
    chk("rd pulse", osd_read_req, 1'b1);
    chk("rd no wr", osd_write_req, 1'b0);
    chkw("rd addr", DW'(osd_read_address), DW'(22'h000001));
    chk("rd grant", ogrant, 1'b1);
    @(negedge iclk);                               // WAIT
    isd_write_ack = 1;
    @(negedge iclk);
    isd_write_ack = 0;
    chk("rd wrong ack ignored", ob_ack, 1'b0);
    isd_read_ack = 1; isd_read_data = WDATA;
    @(negedge iclk);                               // DONE
    isd_read_ack = 0; isd_read_data = '0;
    chk("rd ob_ack", ob_ack, 1'b1);
    chk("rd ob_err", ob_err, 1'b0);
    chk("rd oa_ack", oa_ack, 1'b0);
    chkw("rd ob_rdata", ob_rdata, WDATA);
    chkw("rd oa_rdata kept", oa_rdata, '0);
    ib_req = 0;
    @(negedge iclk);                               // IDLE: spurious ack
    isd_read_ack = 1; isd_read_data = 128'h1111;
    @(negedge iclk);
    isd_read_ack = 0; isd_read_data = '0;
    @(negedge iclk);
    chk("spurious no ack", ob_ack | oa_ack | obusy, 1'b0);
    chkw("spurious rdata held", ob_rdata, WDATA);

    // Round robin from reset with both clients requesting
    apply_reset();
    ia_req = 1; ia_we = 1; ia_address = 22'h00000A; ia_wdata = 128'hA;
    ib_req = 1; ib_we = 1; ib_address = 22'h00000B; ib_wdata = 128'hB;
    for (int i = 0; i < 6; i++) begin
      logic exp_b;
      exp_b = logic'(i % 2);
      wait_pulse($sformatf("rr%0d issue", i));
      chk($sformatf("rr%0d grant", i), ogrant, exp_b);
      chkw($sformatf("rr%0d addr", i), DW'(osd_write_address),
           exp_b ? DW'(22'h00000B) : DW'(22'h00000A));
      @(negedge iclk);                             // WAIT
      isd_write_ack = 1;
      @(negedge iclk);                             // DONE
      isd_write_ack = 0;
      chk($sformatf("rr%0d oa_ack", i), oa_ack, ~exp_b);
      chk($sformatf("rr%0d ob_ack", i), ob_ack, exp_b);
      if (i == 5) begin
        ia_req = 0; ib_req = 0;
      end else if (exp_b) ib_req = 0;
      else                ia_req = 0;
      @(negedge iclk);                             // IDLE
      if (i < 5) begin
        if (exp_b) ib_req = 1;
        else       ia_req = 1;
      end
    end

    // Watchdog: no controller ack, abort after 8 WAIT cycles
    ia_req = 1; ia_we = 1; ia_address = 22'h000155; ia_wdata = 128'h55;
    wait_pulse("to issue");
    seen = 1'b0;
    repeat (8) begin
      @(negedge iclk);
      seen = seen | oa_ack | ob_ack;
    end
    chk("to no early ack", seen, 1'b0);
    @(negedge iclk);                               // ISSUE+1+8
    chk("to oa_ack", oa_ack, 1'b1);
    chk("to oa_err", oa_err, 1'b1);
    chk("to ob_ack", ob_ack, 1'b0);
    ia_req = 0;
    @(negedge iclk);
    isd_write_ack = 1;
    @(negedge iclk);
    isd_write_ack = 0;
    chk("to late ack ignored", oa_ack | ob_ack | obusy, 1'b0);
    chkw("to rdata kept", oa_rdata, '0);

    // Async reset in WAIT
    ib_req = 1; ib_we = 0; ib_address = 22'h000002;
    wait_pulse("ar issue");
    @(negedge iclk);                               // WAIT
    chk("ar busy before", obusy, 1'b1);
    #2 ireset = 1'b1;
    #1;
    chk("ar busy", obusy, 1'b0);
    chk("ar grant", ogrant, 1'b1);
    chkw("ar rd_addr", DW'(osd_read_address), '0);
    chk("ar ob_ack", ob_ack, 1'b0);
    isd_init_done = 0;
    @(negedge iclk);
    ireset = 1'b0;
    seen = 1'b0;
    repeat (4) begin
      @(negedge iclk);
      seen = seen | osd_read_req | osd_write_req | ob_ack | oa_ack | obusy;
    end
    chk("ar init idle", seen, 1'b0);
    ib_req = 0;

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/sdram_client_arbiter.md
Name: sdram_client_arbiter

Overview:
- Two-client round-robin arbiter that sits directly upstream of sdram_controller and drives its write/read request interface.
- Each client issues 128-bit line reads or writes at 22-bit line addresses with a level request/pulse ack handshake.
- The arbiter serialises client transactions to one outstanding controller operation at a time.
- A watchdog timeout returns an error to the client if the controller never acknowledges.

Parameters:
- ADDR_W, 22, line address width (matches controller iwrite_address/iread_address)
- DATA_W, 128, line data width (matches controller iwrite_data/oread_data)
- TIMEOUT_CYCLES, 1024, cycles spent in WAIT without a matching ack before aborting; legal range 2..65535

Ports:
- iclk  in  1  system clock; all state is on its rising edge
- ireset  in  1  reset, asynchronous, active-high
- ia_req / ib_req  in  1  client A / B request; level, held until the client's ack
- ia_we / ib_we  in  1  1 = write, 0 = read; stable while the request is high
- ia_address / ib_address  in  ADDR_W  line address
- ia_wdata / ib_wdata  in  DATA_W  write data
- oa_ack / ob_ack  out  1  one-cycle completion pulse
- oa_err / ob_err  out  1  valid with ack; 1 = timeout abort
- oa_rdata / ob_rdata  out  DATA_W  last read data, registered, held
- osd_write_req  out  1  one-cycle write pulse to controller
- osd_write_address  out  ADDR_W  write address
- osd_write_data  out  DATA_W  write data
- isd_write_ack  in  1  controller write ack
- osd_read_req  out  1  one-cycle read pulse to controller
- osd_read_address  out  ADDR_W  read address
- isd_read_data  in  DATA_W  controller read data, valid with isd_read_ack
- isd_read_ack  in  1  controller read ack
- isd_init_done  in  1  controller SDRAM init complete
- obusy  out  1  high in ISSUE, WAIT and DONE
- ogrant  out  1  client being served or last served (0 = A, 1 = B)

Behaviour:
- Reset values:
  - All outputs are 0: acks, errs, rdata, osd_* (address and data included), obusy.
  - ogrant = 1 (B), so A wins the first tie.
  - State = INIT; timeout counter = 0.
- Reset is asynchronous mid-operation: state returns to INIT immediately and any pending transaction is dropped without an ack.
- INIT:
  - Client requests are ignored.
  - Go to IDLE on the first edge where isd_init_done = 1.
- IDLE:
  - If isd_init_done = 0, go to INIT.
  - Otherwise, if any request is high:
    - Latch the winner's we, address and wdata into the osd_* registers.
    - Set ogrant to the winner and go to ISSUE.
  - Round robin:
    - Single request: that client wins.
    - Both requesting: the client != ogrant wins.
- ISSUE, exactly one cycle:
  - osd_write_req = 1 if we, else osd_read_req = 1.
  - osd_* address and data hold their latched values from ISSUE through DONE.
  - Clear the counter and go to WAIT.
- WAIT:
  - Write op: isd_write_ack = 1 goes to DONE with err = 0.
  - Read op: isd_read_ack = 1 captures isd_read_data into the granted client's rdata, then goes to DONE with err = 0.
  - An ack of the other type is ignored.
  - If the counter reaches TIMEOUT_CYCLES-1 with no matching ack, go to DONE with err = 1; rdata is not updated.
  - The counter increments each cycle in WAIT.
  - isd_init_done is not checked in WAIT.
- DONE, exactly one cycle:
  - The granted client's ack = 1; its err is the registered flag.
  - The other client's ack and err stay 0.
  - Go to IDLE.
- Client rule: the client drops req on the edge at which it samples ack = 1. The arbiter therefore never sees a stale request in the following IDLE cycle.
- Throughput: back-to-back requests take at least 4 cycles each (IDLE, ISSUE, WAIT ≥ 1, DONE).
- Latency: req sampled in IDLE at edge t gives a controller pulse in cycle t+1. Client ack comes one cycle after the edge at which the controller ack is sampled.
- Late or spurious controller acks arriving outside WAIT are ignored.
- oa_rdata / ob_rdata change only on a successful read for that client.

Test Plan:
1. Hold isd_init_done = 0 with ia_req = 1 for 20 cycles, then raise it → no osd_* pulse while low. Exactly one osd_write_req or osd_read_req one cycle after IDLE is entered.
2. A writes addr 22'h000001, data 128'hDEADBEEFCAFEBABE123456789ABCDEF0; model acks 5 cycles later → one-cycle osd_write_req with that address and data; oa_ack pulses once with oa_err = 0; ob_ack stays 0.
3. B reads 22'h000001; model returns that data with isd_read_ack → ob_rdata equals it and ob_ack pulses; oa_rdata is unchanged.
4. A and B both request from reset, each re-requesting immediately after its ack, 6 transactions → grant order A, B, A, B, A, B.
5. TIMEOUT_CYCLES = 8 and the model never acks → oa_ack = 1 with oa_err = 1 at exactly ISSUE+1+8 cycles. A late isd_write_ack afterwards produces no client ack.
6. Assert ireset during WAIT → all outputs return to 0 and ogrant to 1 asynchronously; state is INIT; no client ack is produced.
